// File: rtl/fir_pkg.sv
// fir_pkg: shared types and width helpers for the symmetric FIR MAC.
package fir_pkg;

    // Sequencer states: accept a sample, walk the unique taps, flush the pipe, present result
    typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} fir_state_e;

    // Number of distinct coefficients of an odd-length symmetric filter
    function automatic int f_nuniq(input int ntaps);
        return (ntaps - 1) / 2 + 1;
    endfunction

    // Coefficient / tap index width
    function automatic int f_aw(input int ntaps);
        return $clog2(f_nuniq(ntaps));
    endfunction

    // Accumulator width: pre-added sample times coefficient, plus growth over NUNIQ terms
    function automatic int f_acc_w(input int ntaps, input int data_w, input int coef_w);
        return data_w + 1 + coef_w + f_aw(ntaps);
    endfunction

endpackage

// File: rtl/fir_coef_ram.sv
// fir_coef_ram: NUNIQ x COEF_W coefficient store, gated synchronous write, registered read.
module fir_coef_ram #(
    parameter int NUNIQ  = 28,
    parameter int AW     = 5,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_allow,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [COEF_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [COEF_W-1:0] o_rdata
);
    logic [COEF_W-1:0] r_mem [NUNIQ];
    logic [COEF_W-1:0] r_rdata;
    logic              w_wr_en;

    // Out-of-range addresses and writes outside the allowed states are dropped
    assign w_wr_en = i_we && i_wr_allow && (32'(i_waddr) < 32'(NUNIQ));
    assign o_rdata = r_rdata;

    // Storage and read register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUNIQ; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (w_wr_en) begin
                r_mem[i_waddr] <= i_wdata;
            end
            r_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/sym_fir_mac.sv
// sym_fir_mac: sequential odd-length symmetric FIR, one shared pre-adder/multiplier/accumulator.
// Build macro FIR_SAT_EN: round half up before the shift, clamp to OUT_W, sticky ovf.
module sym_fir_mac
    import fir_pkg::*;
#(
    parameter int NTAPS  = 55,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    localparam int NUNIQ = f_nuniq(NTAPS),
    localparam int AW    = f_aw(NTAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     busy,
    output logic                     ovf
);
    localparam int HALF  = (NTAPS - 1) / 2;
    localparam int ACC_W = f_acc_w(NTAPS, DATA_W, COEF_W);
    localparam int PREW  = DATA_W + 1;
    localparam int PW    = DATA_W + 1 + COEF_W;
    localparam int XW    = $clog2(NTAPS);
    localparam int EW    = ACC_W + OUT_W + 2;

    fir_state_e              r_state, w_state_next;
    logic signed [DATA_W-1:0] r_x [NTAPS];
    logic [AW-1:0]           r_k;
    logic [1:0]              r_drain;
    logic                    r_v1, r_v2, r_in_ready;
    logic signed [PREW-1:0]  w_p, r_p;
    logic [COEF_W-1:0]       w_coef;
    logic signed [PW-1:0]    r_prod;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [OUT_W-1:0] r_out_data, w_fmt;
    logic [XW-1:0]           w_idx_lo, w_idx_hi;
    logic                    w_accept, w_load_out, w_wr_allow, w_last_k;

    assign w_accept   = in_valid && r_in_ready && (r_state == StIdle);
    assign w_last_k   = (r_k == AW'(HALF));
    // Third drain cycle: the last product has landed in the accumulator
    assign w_load_out = (r_state == StDrain) && (r_drain == 2'd2);
    assign w_wr_allow = (r_state == StIdle) || (r_state == StOut);

    fir_coef_ram #(
        .NUNIQ  (NUNIQ),
        .AW     (AW),
        .COEF_W (COEF_W)
    ) u_coef_ram (
        .clk        (clk),
        .rst        (rst),
        .i_wr_allow (w_wr_allow),
        .i_we       (coef_we),
        .i_waddr    (coef_addr),
        .i_wdata    (coef_wdata),
        .i_raddr    (r_k),
        .o_rdata    (w_coef)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept)           w_state_next = StMac;
            StMac:   if (w_last_k)           w_state_next = StDrain;
            StDrain: if (r_drain == 2'd2)    w_state_next = StOut;
            StOut:   if (out_ready)          w_state_next = StIdle;
        endcase
    end

    // Outputs decoded from state and output registers
    always_comb begin
        busy      = (r_state != StIdle);
        out_valid = (r_state == StOut);
        in_ready  = r_in_ready;
        out_data  = r_out_data;
    end

    // Tap index, drain counter and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k        <= '0;
            r_drain    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == StIdle);
            if (w_accept) begin
                r_k <= '0;
            end else if (r_state == StMac && !w_last_k) begin
                r_k <= r_k + AW'(1);
            end
            if (r_state == StMac)        r_drain <= '0;
            else if (r_state == StDrain) r_drain <= r_drain + 2'd1;
        end
    end

    // Delay line shifts once per accepted sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_accept) begin
            for (int i = NTAPS - 1; i > 0; i--) begin
                r_x[i] <= r_x[i-1];
            end
            r_x[0] <= in_data;
        end
    end

    // Pre-adder: fold symmetric taps; the centre tap stands alone
    always_comb begin
        w_idx_lo = XW'(r_k);
        w_idx_hi = XW'(NTAPS - 1) - XW'(r_k);
        if (w_last_k) w_p = PREW'(r_x[w_idx_lo]);
        else          w_p = PREW'(r_x[w_idx_lo]) + PREW'(r_x[w_idx_hi]);
    end

    // Pipe stages 1-2: pre-sum alongside the registered coefficient read, then product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_p    <= '0;
            r_prod <= '0;
        end else begin
            r_v1   <= (r_state == StMac);
            r_p    <= w_p;
            r_v2   <= r_v1;
            r_prod <= PW'(r_p) * PW'($signed(w_coef));
        end
    end

    // Pipe stage 3: accumulate, cleared when a new sample is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_acc <= '0;
        else if (w_accept) r_acc <= '0;
        else if (r_v2)   r_acc <= r_acc + ACC_W'(r_prod);
    end

`ifdef FIR_SAT_EN
    localparam logic [EW-1:0]        RND  = (EW'(1) << SHIFT) >> 1;
    localparam logic signed [EW-1:0] MAXV = $signed({{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    logic signed [EW-1:0] w_shift;
    logic                 w_clamp;
    logic                 r_ovf;

    // Round half up, shift, clamp to the output range
    always_comb begin
        w_shift = (EW'(r_acc) + $signed(RND)) >>> SHIFT;
        w_clamp = 1'b0;
        w_fmt   = OUT_W'(w_shift);
        if (w_shift > MAXV) begin
            w_fmt   = OUT_W'(MAXV);
            w_clamp = 1'b1;
        end else if (w_shift < MINV) begin
            w_fmt   = OUT_W'(MINV);
            w_clamp = 1'b1;
        end
    end

    // Sticky overflow, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_ovf <= 1'b0;
        else if (w_load_out && w_clamp) r_ovf <= 1'b1;
    end

    assign ovf = r_ovf;
`else
    // Floor shift, keep the low OUT_W bits
    always_comb begin
        w_fmt = OUT_W'(EW'(r_acc) >>> SHIFT);
    end

    assign ovf = 1'b0;
`endif

    // Output register, held stable through OUT
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_out_data <= '0;
        else if (w_load_out) r_out_data <= w_fmt;
    end

endmodule

// File: tb/tb_sym_fir_mac.sv
// tb_sym_fir_mac: directed checks on three configurations (5-tap, 55-tap default, 3-tap).
module tb_sym_fir_mac;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 5 taps, SHIFT 0, 32-bit output
    logic               a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1;
    logic signed [15:0] a_in_data = 0;
    logic signed [31:0] a_out_data;
    logic               a_coef_we = 0, a_busy, a_ovf;
    logic [1:0]         a_coef_addr = 0;
    logic [15:0]        a_coef_wdata = 0;

    // defaults (55 taps)
    logic               b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1;
    logic signed [15:0] b_in_data = 0;
    logic signed [15:0] b_out_data;
    logic               b_coef_we = 0, b_busy, b_ovf;
    logic [4:0]         b_coef_addr = 0;
    logic [15:0]        b_coef_wdata = 0;

    // 3 taps, SHIFT 0, 16-bit output
    logic               c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 1;
    logic signed [15:0] c_in_data = 0;
    logic signed [15:0] c_out_data;
    logic               c_coef_we = 0, c_busy, c_ovf;
    logic [0:0]         c_coef_addr = 0;
    logic [15:0]        c_coef_wdata = 0;

    sym_fir_mac #(.NTAPS(5), .SHIFT(0), .OUT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .coef_we(a_coef_we), .coef_addr(a_coef_addr),
        .coef_wdata(a_coef_wdata), .busy(a_busy), .ovf(a_ovf)
    );

    sym_fir_mac u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
        .coef_wdata(b_coef_wdata), .busy(b_busy), .ovf(b_ovf)
    );

    sym_fir_mac #(.NTAPS(3), .SHIFT(0), .OUT_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .coef_we(c_coef_we), .coef_addr(c_coef_addr),
        .coef_wdata(c_coef_wdata), .busy(c_busy), .ovf(c_ovf)
    );

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic a_wcoef(input int addr, input int val);
        a_coef_we    = 1'b1;
        a_coef_addr  = 2'(addr);
        a_coef_wdata = 16'(val);
        @(negedge clk);
        a_coef_we = 1'b0;
    endtask

    task automatic a_send(input string tag, input int d);
        int t = 0;
        while (!a_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_rdy"}, a_in_ready, 1);
        a_in_valid = 1'b1;
        a_in_data  = 16'(d);
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic a_get(input string tag, input int exp);
        int t = 0;
        while (!a_out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_vld"}, a_out_valid, 1);
        check(tag, a_out_data, exp);
        @(negedge clk);
    endtask

    int imp_in  [5] = '{1, 0, 0, 0, 0};
    int imp_exp [5] = '{1, 2, 3, 2, 1};
    int t, lat, per, busy_hi, bad, extra;
    logic seen;
    logic signed [31:0] outd, held;
    int sat_exp [2];
    int ovf_exp [2];

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ovf", c_ovf, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_rise", a_in_ready, 1);

        // Impulse response, coef {1,2,3}
        a_wcoef(0, 1);
        a_wcoef(1, 2);
        a_wcoef(2, 3);
        for (int i = 0; i < 5; i++) begin
            a_send($sformatf("imp_in%0d", i), imp_in[i]);
            a_get($sformatf("imp%0d", i), imp_exp[i]);
        end

        // Backpressure: out_ready low for 10 cycles while a new sample waits
        a_out_ready = 1'b0;
        a_send("bp_in", 5);
        t = 0;
        while (!a_out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        held = a_out_data;
        check("bp_data", held, 5);
        a_in_valid = 1'b1;
        a_in_data  = 16'sd7;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_out_data !== held || a_out_valid !== 1'b1 || a_in_ready !== 1'b0) bad++;
        end
        check("bp_stable", bad, 0);
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_rdy", a_in_ready, 1);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_get("bp_next", 17);
        extra = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (a_out_valid) extra++;
        end
        check("bp_no_dup", extra, 0);

        // Coefficient gating
        a_send("gate_mac_in", 1);
        a_wcoef(0, 7);
        a_get("gate_mac", 30);
        a_send("gate_after_in", 3);
        a_get("gate_after", 36);
        t = 0;
        while (!a_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        a_in_valid   = 1'b1;
        a_in_data    = 16'sd2;
        a_coef_we    = 1'b1;
        a_coef_addr  = 2'd0;
        a_coef_wdata = 16'd4;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_coef_we  = 1'b0;
        a_get("gate_accept_edge", 51);
        a_wcoef(3, 100);
        a_send("gate_range_in", 0);
        a_get("gate_range", 43);

        // Latency and period on the default configuration, continuous input
        b_coef_we    = 1'b1;
        b_coef_addr  = 5'd0;
        b_coef_wdata = 16'd16384;
        @(negedge clk);
        b_coef_we  = 1'b0;
        b_in_data  = 16'sd1000;
        b_in_valid = 1'b1;
        t = 0;
        while (!b_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("lat_first_rdy", b_in_ready, 1);
        lat = 0; per = 0; busy_hi = 0; seen = 1'b0; outd = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) b_in_data = 16'sd2000;
            if (i <= 32 && b_busy) busy_hi++;
            if (!seen && b_out_valid) begin
                seen = 1'b1;
                lat  = i - 1;
                outd = 32'(b_out_data);
            end
            if (b_in_ready) begin
                per = i;
                break;
            end
        end
        check("lat_edges", lat, 31);
        check("period", per, 33);
        check("busy_run", busy_hi, 32);
        check("lat_data0", outd, 500);
        @(negedge clk);
        b_in_valid = 1'b0;
        t = 0;
        while (!b_out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("lat_data1", b_out_data, 1000);

        // Saturation / wrap on 3 taps, coef {1,1}
        sat_exp[0] = 20000;
        ovf_exp[0] = 0;
`ifdef FIR_SAT_EN
        sat_exp[1] = 32767;
        ovf_exp[1] = 1;
`else
        sat_exp[1] = -25536;
        ovf_exp[1] = 0;
`endif
        for (int i = 0; i < 2; i++) begin
            c_coef_we    = 1'b1;
            c_coef_addr  = 1'(i);
            c_coef_wdata = 16'd1;
            @(negedge clk);
        end
        c_coef_we = 1'b0;
        for (int s = 0; s < 2; s++) begin
            t = 0;
            while (!c_in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            c_in_valid = 1'b1;
            c_in_data  = 16'sd20000;
            @(negedge clk);
            c_in_valid = 1'b0;
            t = 0;
            while (!c_out_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("sat_vld%0d", s), c_out_valid, 1);
            check($sformatf("sat_data%0d", s), c_out_data, sat_exp[s]);
            check($sformatf("sat_ovf%0d", s), c_ovf, ovf_exp[s]);
            @(negedge clk);
        end

        // Asynchronous reset 10 cycles into MAC on the default configuration
        t = 0;
        while (!b_in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        b_in_valid = 1'b1;
        b_in_data  = 16'sd5;
        @(negedge clk);
        b_in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("arst_pre_busy", b_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", b_busy, 0);
        check("arst_out_valid", b_out_valid, 0);
        check("arst_in_ready", a_in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_rdy_low", a_in_ready, 0);
        @(negedge clk);
        check("arst_rdy_rise", a_in_ready, 1);
        a_wcoef(1, 2);
        a_wcoef(2, 3);
        a_send("arst_clr_in", 1);
        a_get("arst_clr", 0);
        a_wcoef(0, 1);
        a_send("arst_imp_in", 0);
        a_get("arst_imp", 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
